// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, 16-bit ALU, {INT,C,N,Z} CCR, jump resolution
module ex_stage #(
  parameter int DW = 16,
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [3:0]    alu_op,
  input  logic [1:0]    alu_src1,
  input  logic [DW-1:0] rdst_val,
  input  logic [DW-1:0] rsrc_val,
  input  logic [DW-1:0] data_in,
  input  logic [3:0]    shmt,
  input  logic [3:0]    hash_imm,
  input  logic [1:0]    fwd_a_sel,
  input  logic [1:0]    fwd_b_sel,
  input  logic [DW-1:0] ex_mem_fwd,
  input  logic [DW-1:0] mem_wb_fwd,
  input  logic          set_z,
  input  logic          set_n,
  input  logic          set_c,
  input  logic          set_int,
  input  logic          clr_z,
  input  logic          clr_n,
  input  logic          clr_c,
  input  logic          clr_int,
  input  logic          flags_restore,
  input  logic [3:0]    flags_rst_val,
  input  logic          is_jmp,
  input  logic [1:0]    jmp_sel,
  input  logic          jmp_src,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] store_data,
  output logic [3:0]    flags_out,
  output logic          jmp_taken,
  output logic [PW-1:0] jmp_target
);

  // CCR bit positions {INT,C,N,Z}
  localparam int Z_B = 0;
  localparam int N_B = 1;
  localparam int C_B = 2;

  logic [3:0]    ccr_q, ccr_d;
  logic [DW-1:0] op_a, rsrc_fwd, op_b;
  logic [DW:0]   wide;
  logic [DW-1:0] res;
  logic          upd_zn, upd_c, c_new, cond;
  logic [3:0]    set_v, clr_v, upd_v, alu_v, jclr_v;

  always_comb begin
    case (fwd_a_sel)
      2'b01:   op_a = ex_mem_fwd;
      2'b10:   op_a = mem_wb_fwd;
      default: op_a = rdst_val;
    endcase
    case (fwd_b_sel)
      2'b01:   rsrc_fwd = ex_mem_fwd;
      2'b10:   rsrc_fwd = mem_wb_fwd;
      default: rsrc_fwd = rsrc_val;
    endcase
    case (alu_src1)
      2'b00:   op_b = rsrc_fwd;
      2'b01:   op_b = data_in;
      2'b10:   op_b = {{(DW-4){1'b0}}, shmt};
      default: op_b = {{(DW-4){1'b0}}, hash_imm};
    endcase
  end

  // wide carries the carry/borrow in its top bit; for shifts it holds the bit shifted out
  always_comb begin
    res    = op_a;
    wide   = '0;
    upd_zn = 1'b0;
    upd_c  = 1'b0;
    c_new  = ccr_q[C_B];
    case (alu_op)
      4'd0: begin res = ~op_a; upd_zn = 1'b1; end
      4'd1: begin
        wide = {1'b0, op_a} + (DW+1)'(1);
        res = wide[DW-1:0]; c_new = wide[DW]; upd_zn = 1'b1; upd_c = 1'b1;
      end
      4'd2: begin
        wide = {1'b0, op_a} - (DW+1)'(1);
        res = wide[DW-1:0]; c_new = wide[DW]; upd_zn = 1'b1; upd_c = 1'b1;
      end
      4'd3: res = op_b;
      4'd4: begin
        wide = {1'b0, op_a} + {1'b0, op_b};
        res = wide[DW-1:0]; c_new = wide[DW]; upd_zn = 1'b1; upd_c = 1'b1;
      end
      4'd5: begin
        wide = {1'b0, op_a} - {1'b0, op_b};
        res = wide[DW-1:0]; c_new = wide[DW]; upd_zn = 1'b1; upd_c = 1'b1;
      end
      4'd6: begin res = op_a & op_b; upd_zn = 1'b1; end
      4'd7: begin res = op_a | op_b; upd_zn = 1'b1; end
      4'd8: begin
        wide = {1'b0, op_a} << op_b[3:0];
        res = op_a << op_b[3:0]; c_new = wide[DW]; upd_zn = 1'b1;
        upd_c = (op_b[3:0] != 4'd0);
      end
      4'd9: begin
        wide = {op_a, 1'b0} >> op_b[3:0];
        res = op_a >> op_b[3:0]; c_new = wide[0]; upd_zn = 1'b1;
        upd_c = (op_b[3:0] != 4'd0);
      end
      default: res = op_a;
    endcase
  end

  always_comb begin
    case (jmp_sel)
      2'b00:   cond = ccr_q[Z_B];
      2'b01:   cond = ccr_q[N_B];
      2'b10:   cond = ccr_q[C_B];
      default: cond = 1'b1;
    endcase
  end

  assign alu_result = res;
  assign store_data = rsrc_fwd;
  assign flags_out  = ccr_q;
  assign jmp_taken  = is_jmp & cond & ~stall & ~reset;
  assign jmp_target = {{(PW-DW){1'b0}}, (jmp_src ? data_in : op_a)};

  assign set_v  = {set_int, set_c, set_n, set_z};
  assign clr_v  = {clr_int, clr_c, clr_n, clr_z};
  assign upd_v  = {1'b0, upd_c, upd_zn, upd_zn};
  assign alu_v  = {1'b0, c_new, res[DW-1], (res == '0)};
  assign jclr_v = {1'b0, jmp_taken && jmp_sel == 2'b10,
                   jmp_taken && jmp_sel == 2'b01, jmp_taken && jmp_sel == 2'b00};

  // Per-bit priority: restore > clr > set > ALU > jump clear
  always_comb begin
    ccr_d = ccr_q;
    if (!stall) begin
      for (int i = 0; i < 4; i++) begin
        if (flags_restore)  ccr_d[i] = flags_rst_val[i];
        else if (clr_v[i])  ccr_d[i] = 1'b0;
        else if (set_v[i])  ccr_d[i] = 1'b1;
        else if (upd_v[i])  ccr_d[i] = alu_v[i];
        else if (jclr_v[i]) ccr_d[i] = 1'b0;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (reset) ccr_q <= '0;
    else       ccr_q <= ccr_d;
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with a behavioural reference model
module tb_ex_stage;

  logic        clk = 1'b1;
  logic        reset, stall;
  logic [3:0]  alu_op;
  logic [1:0]  alu_src1;
  logic [15:0] rdst_val, rsrc_val, data_in;
  logic [3:0]  shmt, hash_imm;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] ex_mem_fwd, mem_wb_fwd;
  logic        set_z, set_n, set_c, set_int, clr_z, clr_n, clr_c, clr_int;
  logic        flags_restore;
  logic [3:0]  flags_rst_val;
  logic        is_jmp;
  logic [1:0]  jmp_sel;
  logic        jmp_src;
  logic [15:0] alu_result, store_data;
  logic [3:0]  flags_out;
  logic        jmp_taken;
  logic [31:0] jmp_target;

  ex_stage #(.DW(16), .PW(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .alu_op(alu_op), .alu_src1(alu_src1),
    .rdst_val(rdst_val), .rsrc_val(rsrc_val), .data_in(data_in), .shmt(shmt),
    .hash_imm(hash_imm), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ex_mem_fwd(ex_mem_fwd), .mem_wb_fwd(mem_wb_fwd),
    .set_z(set_z), .set_n(set_n), .set_c(set_c), .set_int(set_int),
    .clr_z(clr_z), .clr_n(clr_n), .clr_c(clr_c), .clr_int(clr_int),
    .flags_restore(flags_restore), .flags_rst_val(flags_rst_val),
    .is_jmp(is_jmp), .jmp_sel(jmp_sel), .jmp_src(jmp_src),
    .alu_result(alu_result), .store_data(store_data), .flags_out(flags_out),
    .jmp_taken(jmp_taken), .jmp_target(jmp_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, stl;
    logic [3:0]  op;
    logic [1:0]  src;
    logic [15:0] rdst, rsrc, din;
    logic [3:0]  sh, himm;
    logic [1:0]  fa, fb;
    logic [15:0] exm, mwb;
    logic [3:0]  setv, clrv;  // {INT,C,N,Z}
    logic        rest;
    logic [3:0]  rstv;
    logic        isj;
    logic [1:0]  jsel;
    logic        jsrc;
  } stim_t;

  typedef struct packed {
    logic [15:0] res, sd;
    logic        jt;
    logic [31:0] tgt;
    logic [3:0]  flags;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] mccr;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, away from the negedge that moves the CCR
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("alu_result", {16'h0, alu_result}, {16'h0, e.res});
      check("store_data", {16'h0, store_data}, {16'h0, e.sd});
      check("jmp_taken", {31'h0, jmp_taken}, {31'h0, e.jt});
      check("jmp_target", jmp_target, e.tgt);
      check("flags_out", {28'h0, flags_out}, {28'h0, e.flags});
    end
  end

  function automatic logic [15:0] pick(input logic [1:0] s, input logic [15:0] r,
                                       input logic [15:0] e, input logic [15:0] m);
    if (s == 2'd1) return e;
    if (s == 2'd2) return m;
    return r;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.op = 4'd10;
    return s;
  endfunction

  task automatic run(input stim_t s);
    logic [15:0] a, r, b, res;
    int ai, bi, n, sum;
    logic zn, cu, cv, cond, jt;
    logic [3:0] upd, val, jclr, nxt;
    exp_t e;

    reset = s.rst; stall = s.stl; alu_op = s.op; alu_src1 = s.src;
    rdst_val = s.rdst; rsrc_val = s.rsrc; data_in = s.din; shmt = s.sh; hash_imm = s.himm;
    fwd_a_sel = s.fa; fwd_b_sel = s.fb; ex_mem_fwd = s.exm; mem_wb_fwd = s.mwb;
    {set_int, set_c, set_n, set_z} = s.setv;
    {clr_int, clr_c, clr_n, clr_z} = s.clrv;
    flags_restore = s.rest; flags_rst_val = s.rstv;
    is_jmp = s.isj; jmp_sel = s.jsel; jmp_src = s.jsrc;

    a = pick(s.fa, s.rdst, s.exm, s.mwb);
    r = pick(s.fb, s.rsrc, s.exm, s.mwb);
    case (s.src)
      2'd0: b = r;
      2'd1: b = s.din;
      2'd2: b = {12'h0, s.sh};
      default: b = {12'h0, s.himm};
    endcase
    ai = int'(a); bi = int'(b); n = int'(b[3:0]);
    zn = 1'b0; cu = 1'b0; cv = 1'b0; res = a;
    case (s.op)
      4'd0: begin res = ~a; zn = 1; end
      4'd1: begin res = 16'((ai + 1) % 65536); zn = 1; cu = 1; cv = (ai == 65535); end
      4'd2: begin res = 16'((ai + 65535) % 65536); zn = 1; cu = 1; cv = (ai == 0); end
      4'd3: res = b;
      4'd4: begin sum = ai + bi; res = 16'(sum % 65536); zn = 1; cu = 1; cv = (sum > 65535); end
      4'd5: begin res = 16'((ai - bi + 65536) % 65536); zn = 1; cu = 1; cv = (ai < bi); end
      4'd6: begin res = a & b; zn = 1; end
      4'd7: begin res = a | b; zn = 1; end
      4'd8: begin
        res = 16'((ai << n) % 65536); zn = 1;
        if (n > 0) begin cu = 1; cv = ((ai >> (16 - n)) & 1) == 1; end
      end
      4'd9: begin
        res = 16'(ai >> n); zn = 1;
        if (n > 0) begin cu = 1; cv = ((ai >> (n - 1)) & 1) == 1; end
      end
      default: res = a;
    endcase

    case (s.jsel)
      2'd0: cond = mccr[0];
      2'd1: cond = mccr[1];
      2'd2: cond = mccr[2];
      default: cond = 1'b1;
    endcase
    jt = s.isj && cond && !s.stl && !s.rst;

    e.res = res; e.sd = r; e.jt = jt;
    e.tgt = {16'h0, (s.jsrc ? s.din : a)};
    e.flags = mccr;
    exp_q.push_back(e);

    upd  = {1'b0, cu, zn, zn};
    val  = {1'b0, cv, res[15], res == 16'h0};
    jclr = 4'b0;
    if (jt && s.jsel != 2'd3) jclr[s.jsel] = 1'b1;
    nxt = mccr;
    for (int i = 0; i < 4; i++) begin
      if (s.rest)         nxt[i] = s.rstv[i];
      else if (s.clrv[i]) nxt[i] = 1'b0;
      else if (s.setv[i]) nxt[i] = 1'b1;
      else if (upd[i])    nxt[i] = val[i];
      else if (jclr[i])   nxt[i] = 1'b0;
    end
    if (s.rst)       mccr = 4'h0;
    else if (!s.stl) mccr = nxt;

    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    stim_t s;
    int waited;
    s = idle();
    s.rst = 1'b1;
    mccr = 4'h0;
    run(s);  // first negedge clears the CCR; this vector's flags are not yet defined
    void'(exp_q.pop_back());
    s.isj = 1'b1; s.jsel = 2'd3;
    run(s);  // reset state: CCR=0, jump suppressed

    s = idle(); s.op = 4'd4; s.rdst = 16'hFFFF; s.rsrc = 16'h0001;
    run(s);
    s = idle(); s.isj = 1'b1; s.jsel = 2'd0; s.jsrc = 1'b1; s.din = 16'h0040;
    run(s);
    s = idle(); s.op = 4'd4; s.rdst = 16'hFFFF; s.rsrc = 16'h0001;
    s.setv = 4'b0100; s.clrv = 4'b0100;
    run(s);
    s = idle(); s.rest = 1'b1; s.rstv = 4'b1010; s.setv = 4'b0001;
    run(s);
    s = idle(); s.stl = 1'b1; s.op = 4'd5; s.rdst = 16'h0000; s.rsrc = 16'h0001;
    s.isj = 1'b1; s.jsel = 2'd3;
    run(s);
    s = idle(); s.op = 4'd1; s.fa = 2'd1; s.exm = 16'h1234; s.rdst = 16'h0000;
    s.fb = 2'd2; s.mwb = 16'hABCD; s.rsrc = 16'h5555;
    run(s);
    s = idle(); s.op = 4'd8; s.rdst = 16'h8001; s.src = 2'd2; s.sh = 4'd1;
    run(s);
    s.sh = 4'd0; s.rdst = 16'h0003;
    run(s);
    s = idle(); s.op = 4'd4; s.rdst = 16'hFFFF; s.rsrc = 16'h0001; s.rst = 1'b1;
    run(s);
    run(idle());

    for (int k = 0; k < 400; k++) begin
      s.rst  = ($urandom_range(0, 39) == 0);
      s.stl  = ($urandom_range(0, 7) == 0);
      s.op   = 4'($urandom);
      s.src  = 2'($urandom);
      s.rdst = rnd_word(); s.rsrc = rnd_word(); s.din = rnd_word();
      s.exm  = rnd_word(); s.mwb = rnd_word();
      s.sh   = 4'($urandom); s.himm = 4'($urandom);
      s.fa   = 2'($urandom); s.fb = 2'($urandom);
      s.setv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      s.clrv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      s.rest = ($urandom_range(0, 11) == 0);
      s.rstv = 4'($urandom);
      s.isj  = ($urandom_range(0, 2) == 0);
      s.jsel = 2'($urandom);
      s.jsrc = 1'($urandom);
      run(s);
    end
    run(idle());

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
